// File: rtl/reg_write_arbiter_if.sv
// Port bundle between the requesters / register bank and reg_write_arbiter.
// Handshake: Req is a level held by a requester until its one-hot Done pulse;
// Grant is the one-hot owner for the GRANT and WRITE cycles, Done pulses for one
// cycle when the write has finished, and FlushReq is a level sampled only in IDLE.
interface reg_write_arbiter_if #(
    parameter int NREQ = 4,
    parameter int NREG = 8,
    parameter int AW   = 3,
    parameter int DW   = 5
) ();
    logic [NREQ-1:0]    Req;
    logic [NREQ*AW-1:0] ReqAddr;
    logic [NREQ*DW-1:0] ReqData;
    logic               FlushReq;
    logic [NREQ-1:0]    Grant;
    logic [NREQ-1:0]    Done;
    logic [NREG-1:0]    RegLoad;
    logic [NREG-1:0]    RegClear;
    logic [DW-1:0]      WrData;
    logic               Busy;
    logic               AddrErr;
    logic [2:0]         DbgState;

    modport master (
        output Req, ReqAddr, ReqData, FlushReq,
        input  Grant, Done, RegLoad, RegClear, WrData, Busy, AddrErr, DbgState
    );

    modport slave (
        input  Req, ReqAddr, ReqData, FlushReq,
        output Grant, Done, RegLoad, RegClear, WrData, Busy, AddrErr, DbgState
    );
endinterface

// File: rtl/reg_write_arbiter.sv
// Write-port sequencer and arbiter for a bank of NREG registers, with bank flush.
// Define REGARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module reg_write_arbiter #(
    parameter int NREQ = 4,
    parameter int NREG = 8,
    parameter int AW   = 3,
    parameter int DW   = 5
) (
    input logic                Clock,
    input logic                Clear,
    reg_write_arbiter_if.slave bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [AW:0] NREG_LIMIT = (AW+1)'(NREG);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] GRANT = 3'd1;
    localparam logic [2:0] WRITE = 3'd2;
    localparam logic [2:0] DONE  = 3'd3;
    localparam logic [2:0] FLUSH = 3'd4;

    if ((1 << AW) < NREG) begin : gBadAddrWidth
        $error("reg_write_arbiter: AW too small for NREG");
    end

    logic [2:0]      state;
    logic [PW-1:0]   winner;
    logic [PW-1:0]   latWin;
    logic [AW-1:0]   latAddr;
    logic [AW-1:0]   selAddr;
    logic [DW-1:0]   selData;
    logic            anyReq;
    logic            addrOk;
    logic [NREG-1:0] loadVec;

    assign anyReq       = |bus.Req;
    assign addrOk       = {1'b0, latAddr} < NREG_LIMIT;
    assign loadVec      = addrOk ? (NREG'(1) << latAddr) : '0;
    assign bus.DbgState = state;

`ifdef REGARB_FIXED_PRIO_EN
    always_comb begin
        winner = '0;
        for (int i = NREQ-1; i >= 0; i--) begin
            if (bus.Req[i]) winner = PW'(i);
        end
    end
`else
    logic [PW-1:0]     ptr;
    logic [PW-1:0]     nextPtr;
    logic [2*NREQ-1:0] reqDbl;
    logic [NREQ-1:0]   reqRot;
    logic [PW-1:0]     offset;
    logic [PW:0]       sum;

    // Rotate Req so bit 0 is the requester at ptr, then map the first hit back.
    always_comb begin
        reqDbl = {bus.Req, bus.Req} >> ptr;
        reqRot = reqDbl[NREQ-1:0];
        offset = '0;
        for (int i = NREQ-1; i >= 0; i--) begin
            if (reqRot[i]) offset = PW'(i);
        end
        sum = {1'b0, ptr} + {1'b0, offset};
        if (sum >= (PW+1)'(NREQ)) begin
            winner = PW'(sum - (PW+1)'(NREQ));
        end else begin
            winner = sum[PW-1:0];
        end
    end

    assign nextPtr = (latWin == PW'(NREQ-1)) ? '0 : latWin + PW'(1);
`endif

    always_comb begin
        selAddr = '0;
        selData = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (winner == PW'(i)) begin
                selAddr = bus.ReqAddr[i*AW +: AW];
                selData = bus.ReqData[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            state        <= IDLE;
            latWin       <= '0;
            latAddr      <= '0;
            bus.Grant    <= '0;
            bus.Done     <= '0;
            bus.RegLoad  <= '0;
            bus.RegClear <= '0;
            bus.WrData   <= '0;
            bus.Busy     <= 1'b0;
            bus.AddrErr  <= 1'b0;
`ifndef REGARB_FIXED_PRIO_EN
            ptr          <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.FlushReq) begin
                        state        <= FLUSH;
                        bus.RegClear <= '1;
                        bus.Busy     <= 1'b1;
                    end else if (anyReq) begin
                        state      <= GRANT;
                        latWin     <= winner;
                        latAddr    <= selAddr;
                        bus.WrData <= selData;
                        bus.Grant  <= NREQ'(1) << winner;
                        bus.Busy   <= 1'b1;
                    end else begin
                        bus.Busy <= 1'b0;
                    end
                end
                GRANT: begin
                    state       <= WRITE;
                    bus.RegLoad <= loadVec;
                end
                WRITE: begin
                    state       <= DONE;
                    bus.RegLoad <= '0;
                    bus.Grant   <= '0;
                    bus.Done    <= NREQ'(1) << latWin;
                    bus.AddrErr <= ~addrOk;
                end
                DONE: begin
                    state       <= IDLE;
                    bus.Done    <= '0;
                    bus.AddrErr <= 1'b0;
                    bus.Busy    <= 1'b0;
`ifndef REGARB_FIXED_PRIO_EN
                    ptr         <= nextPtr;
`endif
                end
                FLUSH: begin
                    state        <= IDLE;
                    bus.RegClear <= '0;
                    bus.Busy     <= 1'b0;
                end
                default: begin
                    state        <= IDLE;
                    bus.Grant    <= '0;
                    bus.Done     <= '0;
                    bus.RegLoad  <= '0;
                    bus.RegClear <= '0;
                    bus.Busy     <= 1'b0;
                    bus.AddrErr  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter: directed scenarios plus random traffic, all checked
// against a transaction-level model that queues the expected output of every cycle.
module tb_reg_write_arbiter;
    localparam int NREQ = 4;
    localparam int NREG = 8;
    localparam int AW   = 3;
    localparam int DW   = 5;
    localparam int OW   = 2*NREQ + 2*NREG + DW + 2;

    logic Clock = 1'b0;
    logic Clear;
    int   nChecks = 0;
    int   nErrors = 0;

    logic [OW-1:0] expQ[$];
    int            mPtr = 0;
    logic [DW-1:0] mWd  = '0;

    reg_write_arbiter_if #(.NREQ(NREQ), .NREG(NREG), .AW(AW), .DW(DW)) bus ();

    reg_write_arbiter #(.NREQ(NREQ), .NREG(NREG), .AW(AW), .DW(DW)) dut (
        .Clock(Clock),
        .Clear(Clear),
        .bus  (bus)
    );

    always #5 Clock = ~Clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [OW-1:0] mk(logic [NREQ-1:0] g, logic [NREQ-1:0] d,
                                         logic [NREG-1:0] ld, logic [NREG-1:0] cl,
                                         logic [DW-1:0] wd, logic busy, logic aerr);
        return {g, d, ld, cl, wd, busy, aerr};
    endfunction

    function automatic logic [OW-1:0] obs();
        return {bus.Grant, bus.Done, bus.RegLoad, bus.RegClear, bus.WrData, bus.Busy, bus.AddrErr};
    endfunction

    function automatic int pickWinner();
        int w;
        w = -1;
`ifdef REGARB_FIXED_PRIO_EN
        for (int k = NREQ-1; k >= 0; k--) if (bus.Req[k]) w = k;
`else
        for (int k = NREQ-1; k >= 0; k--) if (bus.Req[(mPtr + k) % NREQ]) w = (mPtr + k) % NREQ;
`endif
        return w;
    endfunction

    // Decide what the arbiter must do from an idle point and queue every cycle of it.
    task automatic modelStep();
        int              w;
        logic [AW-1:0]   a;
        logic [DW-1:0]   d;
        logic [NREQ-1:0] g;
        logic [NREG-1:0] ld;
        if (bus.FlushReq) begin
            expQ.push_back(mk('0, '0, '0, '1, mWd, 1'b1, 1'b0));
            expQ.push_back(mk('0, '0, '0, '0, mWd, 1'b0, 1'b0));
        end else if (bus.Req != '0) begin
            w   = pickWinner();
            a   = AW'(bus.ReqAddr >> (w*AW));
            d   = DW'(bus.ReqData >> (w*DW));
            g   = NREQ'(1) << w;
            ld  = (int'(a) < NREG) ? (NREG'(1) << a) : '0;
            mWd = d;
            expQ.push_back(mk(g, '0, '0, '0, d, 1'b1, 1'b0));
            expQ.push_back(mk(g, '0, ld, '0, d, 1'b1, 1'b0));
            expQ.push_back(mk('0, g, '0, '0, d, 1'b1, ld == '0));
            expQ.push_back(mk('0, '0, '0, '0, d, 1'b0, 1'b0));
            mPtr = (w + 1) % NREQ;
        end else begin
            expQ.push_back(mk('0, '0, '0, '0, mWd, 1'b0, 1'b0));
        end
    endtask

    always @(posedge Clear) begin
        expQ.delete();
        mPtr = 0;
        mWd  = '0;
    end

    always @(posedge Clock) begin
        logic [OW-1:0] e;
        if (Clear) begin
            expQ.delete();
            mPtr = 0;
            mWd  = '0;
            #1;
            check("reset_outputs", 32'(obs()), 32'(0));
        end else begin
            if (expQ.size() == 0) modelStep();
            #1;
            if (!Clear) begin
                e = expQ.pop_front();
                check("cycle_outputs", 32'(obs()), 32'(e));
            end
        end
    end

    task automatic tick();
        @(posedge Clock);
        #2;
    endtask

    task automatic setReq(int i, logic [AW-1:0] a, logic [DW-1:0] d);
        bus.Req[i] = 1'b1;
        bus.ReqAddr = (bus.ReqAddr & ~((NREQ*AW)'({AW{1'b1}}) << (i*AW))) | ((NREQ*AW)'(a) << (i*AW));
        bus.ReqData = (bus.ReqData & ~((NREQ*DW)'({DW{1'b1}}) << (i*DW))) | ((NREQ*DW)'(d) << (i*DW));
    endtask

    task automatic idleFor(int n);
        bus.Req      = '0;
        bus.FlushReq = 1'b0;
        repeat (n) tick();
    endtask

    task automatic doReset();
        @(negedge Clock);
        Clear = 1'b1;
        @(negedge Clock);
        Clear = 1'b0;
    endtask

    initial begin
        logic [NREQ-1:0] expG;
        bit              found;
        Clear        = 1'b1;
        bus.Req      = '0;
        bus.ReqAddr  = '0;
        bus.ReqData  = '0;
        bus.FlushReq = 1'b0;
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        Clear = 1'b0;
        tick();
        check("idle_busy", 32'(bus.Busy), 32'(0));

        // Single write from requester 2 to register 5
        @(negedge Clock);
        setReq(2, 3'd5, 5'd10);
        tick();
        check("t1_grant_g", 32'(bus.Grant), 32'(4'b0100));
        check("t1_busy_g", 32'(bus.Busy), 32'(1));
        bus.Req = '0;
        tick();
        check("t1_grant_w", 32'(bus.Grant), 32'(4'b0100));
        check("t1_load", 32'(bus.RegLoad), 32'(8'b0010_0000));
        check("t1_wrdata", 32'(bus.WrData), 32'(10));
        tick();
        check("t1_done", 32'(bus.Done), 32'(4'b0100));
        check("t1_grant_off", 32'(bus.Grant), 32'(0));
        tick();
        check("t1_busy_after", 32'(bus.Busy), 32'(0));
        check("t1_wrdata_kept", 32'(bus.WrData), 32'(10));

        // Fairness with every requester held high from reset
        doReset();
        for (int i = 0; i < NREQ; i++) setReq(i, AW'(i + 1), DW'(i + 20));
        for (int k = 0; k < 5; k++) begin
            found = 1'b0;
            for (int t = 0; t < 10 && !found; t++) begin
                tick();
                if (bus.Grant != '0) found = 1'b1;
            end
`ifdef REGARB_FIXED_PRIO_EN
            expG = 4'b0001;
`else
            expG = 4'b0001 << (k % NREQ);
`endif
            check("t2_grant_order", 32'(bus.Grant), 32'(expG));
            tick();
        end
        idleFor(6);

        // Flush and a request in the same idle cycle
        @(negedge Clock);
        bus.FlushReq = 1'b1;
        setReq(1, 3'd0, 5'd3);
        tick();
        check("t3_clear", 32'(bus.RegClear), 32'(8'hFF));
        check("t3_noload", 32'(bus.RegLoad), 32'(0));
        bus.FlushReq = 1'b0;
        tick();
        check("t3_idle_busy", 32'(bus.Busy), 32'(0));
        tick();
        check("t3_grant", 32'(bus.Grant), 32'(4'b0010));
        idleFor(5);

        // Flush raised while requester 3 is granted
        @(negedge Clock);
        setReq(3, 3'd2, 5'd21);
        tick();
        check("t4_grant", 32'(bus.Grant), 32'(4'b1000));
        bus.FlushReq = 1'b1;
        bus.Req      = '0;
        tick();
        check("t4_load", 32'(bus.RegLoad), 32'(8'b0000_0100));
        check("t4_noclear", 32'(bus.RegClear), 32'(0));
        tick();
        check("t4_done", 32'(bus.Done), 32'(4'b1000));
        tick();
        check("t4_idle_busy", 32'(bus.Busy), 32'(0));
        tick();
        check("t4_flush", 32'(bus.RegClear), 32'(8'hFF));
        idleFor(4);

        // Data changed and Req dropped after the latch edge
        @(negedge Clock);
        setReq(0, 3'd1, 5'd7);
        tick();
        setReq(0, 3'd1, 5'd31);
        bus.Req = '0;
        tick();
        check("t5_wrdata", 32'(bus.WrData), 32'(7));
        check("t5_load", 32'(bus.RegLoad), 32'(8'b0000_0010));
        tick();
        check("t5_done", 32'(bus.Done), 32'(4'b0001));
        idleFor(4);

        // Asynchronous reset in the middle of a WRITE cycle
        @(negedge Clock);
        setReq(1, 3'd3, 5'd9);
        tick();
        tick();
        check("t6_load_pre", 32'(bus.RegLoad), 32'(8'b0000_1000));
        #3;
        Clear = 1'b1;
        #1;
        check("t6_load_rst", 32'(bus.RegLoad), 32'(0));
        check("t6_grant_rst", 32'(bus.Grant), 32'(0));
        check("t6_wrdata_rst", 32'(bus.WrData), 32'(0));
        check("t6_busy_rst", 32'(bus.Busy), 32'(0));
        @(negedge Clock);
        Clear = 1'b0;
        setReq(0, 3'd4, 5'd1);
        tick();
        check("t6_grant_after", 32'(bus.Grant), 32'(4'b0001));
        idleFor(5);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            @(negedge Clock);
            bus.Req      = ($urandom_range(0, 2) == 0) ? '0 : NREQ'($urandom_range(0, 15));
            bus.FlushReq = ($urandom_range(0, 11) == 0);
            bus.ReqAddr  = (NREQ*AW)'($urandom);
            bus.ReqData  = (NREQ*DW)'($urandom);
        end
        idleFor(6);

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end
endmodule
